uart_cfg_regfile: RTL and testbench
===================================

Name: uart_cfg_regfile

Overview:
Parametrised configuration register file for the UART clock/framing path. It replaces the fixed single-register baud store with an addressable bank of NUM_REGS registers. It uses an explicit read/write strobe, error reporting, a sticky lock, and a restore-defaults command. It sits between the command decoder (addr/wdata/valid handshake) and the baud generator and frame logic, which consume its decoded outputs.

Parameters:
DATA_W, 4, width of write/read data bus; minimum 4
ADDR_W, 4, width of register address
NUM_REGS, 6, number of implemented registers; 4 <= NUM_REGS <= 2**ADDR_W
BAUD_RST, 1, reset/default value of BAUD register (3 bits)
PAR_RST, 0, reset/default value of FRAME register (2 bits)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
addr  input  ADDR_W  register address
wdata  input  DATA_W  write data
wr  input  1  1 = write, 0 = read; sampled with valid
valid  input  1  request strobe
ack  output  1  one-cycle acknowledge of an accepted request
rdata  output  DATA_W  read data; valid only while rdata_valid=1, else 0
rdata_valid  output  1  one-cycle, coincident with ack on successful read
err  output  1  one-cycle, coincident with ack on a rejected request
baud  output  3  current baud select
parity  output  2  current parity mode
locked  output  1  lock status
cfg_update  output  1  one-cycle pulse when baud or parity value changes

Behaviour:
- Register map:
  - 0 CMD: write with wdata[0]=1 restores BAUD and FRAME to BAUD_RST/PAR_RST and clears scratch registers; wdata[0]=0 is a no-op write. Read returns {zeros, locked}.
  - 1 BAUD: bits[2:0]; upper wdata bits ignored; reads zero-extended.
  - 2 FRAME: bits[1:0].
  - 3 LOCK: writing wdata[0]=1 sets lock; writing 0 is ignored (lock is sticky until rst). Read returns lock.
  - 4..NUM_REGS-1: DATA_W-bit scratch registers, reset 0.
- FSM with two states:
  - IDLE: valid=1 is accepted. Next state is RESP.
  - RESP: valid is ignored, no new request is accepted. Next state is IDLE unconditionally.
  - Peak throughput is one request per 2 cycles. valid held high is re-accepted every second cycle.
- Latency: request sampled at edge T. Register update, ack, rdata/rdata_valid and err are all registered and visible after edge T (during cycle T+1). They clear after edge T+1.
- err=1 (register unchanged, rdata_valid=0, ack still 1) when:
  - addr >= NUM_REGS; or
  - locked=1 and the request is a write to addr 0, 1 or 2.
- Reads are never blocked by lock.
- Writes to LOCK while locked: accepted, no error, no effect.
- cfg_update pulses one cycle coincident with ack only if the baud or parity value actually changed. A write of the same value, or a restore when values are already default, gives no pulse.
- Reset values:
  - ack=0, rdata=0, rdata_valid=0, err=0, cfg_update=0, locked=0.
  - baud=BAUD_RST, parity=PAR_RST, scratch=0, state=IDLE.
- Reset mid-transaction (rst during RESP) aborts: all outputs go to reset values immediately, with no pending ack afterwards.
- baud/parity/locked are direct register outputs. A new value is visible in the same cycle as ack.

Test Plan:
- Reset: assert rst -> baud=1, parity=0, locked=0, ack/err/rdata_valid=0. Read addr 1 -> ack=1, rdata_valid=1, rdata=4'b0001 one cycle after valid.
- Write addr1=5 then read addr1 -> first: ack=1, err=0, baud=5, cfg_update=1. Second: rdata=4'b0101, rdata_valid=1. Rewrite 5 -> cfg_update=0.
- Lock: write addr3=1, then write addr1=2 -> err=1, ack=1, baud unchanged. Write addr0=1 -> err=1. Read addr0 -> rdata=1, err=0.
- Out-of-range: NUM_REGS=6, read addr 9 -> ack=1, err=1, rdata_valid=0, rdata=0. Scratch addr5 write 4'hA then read -> 4'hA.
- valid held high 6 cycles with wr=1, addr1, changing wdata -> exactly 3 acks on alternating cycles. Samples in RESP cycles are ignored.
- Restore: set baud=6, parity=3, write addr0=1 -> baud=1, parity=0, cfg_update=1. Assert rst in RESP cycle -> ack=0 immediately and stays 0.

Source files
------------

// File: rtl/uart_cfg_regfile_if.sv
// Request/response bus between the command decoder (master) and the UART
// configuration register file (slave).
interface uart_cfg_regfile_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              wr;
  logic              valid;
  logic              ack;
  logic [DATA_W-1:0] rdata;
  logic              rdata_valid;
  logic              err;

  modport master (
    output addr, wdata, wr, valid,
    input  ack, rdata, rdata_valid, err
  );

  modport slave (
    input  addr, wdata, wr, valid,
    output ack, rdata, rdata_valid, err
  );
endinterface

// File: rtl/uart_cfg_regfile.sv
// Addressable UART configuration bank: CMD/BAUD/FRAME/LOCK plus scratch registers,
// with a two-state request/response handshake, sticky lock and restore-defaults.
module uart_cfg_regfile #(
  parameter int         DATA_W   = 4,
  parameter int         ADDR_W   = 4,
  parameter int         NUM_REGS = 6,
  parameter logic [2:0] BAUD_RST = 3'd1,
  parameter logic [1:0] PAR_RST  = 2'd0
) (
  input  logic                clk,
  input  logic                rst,
  uart_cfg_regfile_if.slave   bus,
  output logic [2:0]          baud,
  output logic [1:0]          parity,
  output logic                locked,
  output logic                cfg_update
);

  localparam int              NSCR       = (NUM_REGS > 4) ? NUM_REGS - 4 : 1;
  localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

  typedef enum logic {IDLE, RESP} state_t;

  state_t            state, state_nx;
  logic [DATA_W-1:0] scratch    [NSCR];
  logic [DATA_W-1:0] scratch_nx [NSCR];
  logic [2:0]        baud_nx;
  logic [1:0]        parity_nx;
  logic              locked_nx;
  logic [DATA_W-1:0] rd_val;
  logic              accept, in_range, reject, do_write, rd_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      IDLE: if (bus.valid) begin
        accept   = 1'b1;
        state_nx = RESP;
      end
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Lock only guards the CMD/BAUD/FRAME writes; reads and LOCK writes pass.
  always_comb begin
    in_range = {1'b0, bus.addr} < NUM_REGS_W;
    reject   = !in_range || (locked && bus.wr && (bus.addr < ADDR_W'(3)));
    do_write = accept && bus.wr && !reject;
    rd_ok    = accept && !bus.wr && !reject;
  end

  always_comb begin
    baud_nx    = baud;
    parity_nx  = parity;
    locked_nx  = locked;
    scratch_nx = scratch;
    rd_val     = '0;
    case (bus.addr)
      ADDR_W'(0): begin
        rd_val = DATA_W'(locked);
        if (do_write && bus.wdata[0]) begin
          baud_nx   = BAUD_RST;
          parity_nx = PAR_RST;
          for (int i = 0; i < NSCR; i++) scratch_nx[i] = '0;
        end
      end
      ADDR_W'(1): begin
        rd_val = DATA_W'(baud);
        if (do_write) baud_nx = bus.wdata[2:0];
      end
      ADDR_W'(2): begin
        rd_val = DATA_W'(parity);
        if (do_write) parity_nx = bus.wdata[1:0];
      end
      ADDR_W'(3): begin
        rd_val = DATA_W'(locked);
        if (do_write && bus.wdata[0]) locked_nx = 1'b1;
      end
      default: begin
        for (int i = 0; i < NUM_REGS - 4; i++) begin
          if (bus.addr == ADDR_W'(i + 4)) begin
            rd_val = scratch[i];
            if (do_write) scratch_nx[i] = bus.wdata;
          end
        end
      end
    endcase
  end

  // NOTE: the scratch array is a handful of flops that restore must clear anyway,
  // so it takes the async reset like the rest rather than being treated as RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.ack         <= 1'b0;
      bus.err         <= 1'b0;
      bus.rdata_valid <= 1'b0;
      bus.rdata       <= '0;
      baud            <= BAUD_RST;
      parity          <= PAR_RST;
      locked          <= 1'b0;
      cfg_update      <= 1'b0;
      for (int i = 0; i < NSCR; i++) scratch[i] <= '0;
    end else begin
      bus.ack         <= accept;
      bus.err         <= accept && reject;
      bus.rdata_valid <= rd_ok;
      bus.rdata       <= rd_ok ? rd_val : '0;
      baud            <= baud_nx;
      parity          <= parity_nx;
      locked          <= locked_nx;
      cfg_update      <= (baud_nx != baud) || (parity_nx != parity);
      scratch         <= scratch_nx;
    end
  end

endmodule

// File: tb/tb_uart_cfg_regfile.sv
// Scoreboard bench for uart_cfg_regfile: a behavioural model queues the expected
// response of every accepted request and a monitor compares it when ack appears.
module tb_uart_cfg_regfile;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] baud;
  logic [1:0] parity;
  logic       locked;
  logic       cfg_update;

  uart_cfg_regfile_if #(.DATA_W(4), .ADDR_W(4)) bus ();

  uart_cfg_regfile #(
    .DATA_W(4), .ADDR_W(4), .NUM_REGS(6), .BAUD_RST(3'd1), .PAR_RST(2'd0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .baud       (baud),
    .parity     (parity),
    .locked     (locked),
    .cfg_update (cfg_update)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       err;
    logic       rv;
    logic [3:0] rdata;
    logic       cu;
    logic [2:0] baud;
    logic [1:0] par;
    logic       lock;
  } exp_t;

  exp_t sb[$];
  int   total    = 0;
  int   bad      = 0;
  int   ack_seen = 0;

  logic [2:0] m_baud;
  logic [1:0] m_par;
  logic       m_lock;
  logic [3:0] m_scr [16];

  task automatic model_reset();
    m_baud = 3'd1;
    m_par  = 2'd0;
    m_lock = 1'b0;
    for (int i = 0; i < 16; i++) m_scr[i] = 4'h0;
  endtask

  // Apply one accepted request to the model and queue the response it implies.
  task automatic push_req(input logic w, input logic [3:0] a, input logic [3:0] d);
    exp_t       e;
    logic       rej;
    logic [2:0] ob = m_baud;
    logic [1:0] op = m_par;
    logic [3:0] rd = 4'h0;
    rej = (a >= 4'd6) || (m_lock && w && (a < 4'd3));
    if (!rej && !w) begin
      case (a)
        4'd0, 4'd3: rd = {3'b000, m_lock};
        4'd1:       rd = {1'b0, m_baud};
        4'd2:       rd = {2'b00, m_par};
        default:    rd = m_scr[a];
      endcase
    end
    if (!rej && w) begin
      case (a)
        4'd0: if (d[0]) begin
          m_baud = 3'd1;
          m_par  = 2'd0;
          for (int i = 0; i < 16; i++) m_scr[i] = 4'h0;
        end
        4'd1:    m_baud = d[2:0];
        4'd2:    m_par  = d[1:0];
        4'd3:    if (d[0]) m_lock = 1'b1;
        default: m_scr[a] = d;
      endcase
    end
    e.err   = rej;
    e.rv    = !rej && !w;
    e.rdata = rd;
    e.cu    = (m_baud != ob) || (m_par != op);
    e.baud  = m_baud;
    e.par   = m_par;
    e.lock  = m_lock;
    sb.push_back(e);
  endtask

  // Monitor: every ack pops one expected response.
  always @(negedge clk) begin
    if (!rst && bus.ack === 1'b1) begin
      exp_t act;
      exp_t exp_v;
      ack_seen++;
      act = {bus.err, bus.rdata_valid, bus.rdata, cfg_update, baud, parity, locked};
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_ack: got resp=%h with empty scoreboard", act);
      end else begin
        exp_v = sb.pop_front();
        if (act !== exp_v) begin
          bad++;
          $display("FAIL resp: got err=%b rv=%b rdata=%h cu=%b baud=%0d par=%0d lock=%b, want err=%b rv=%b rdata=%h cu=%b baud=%0d par=%0d lock=%b",
                   act.err, act.rv, act.rdata, act.cu, act.baud, act.par, act.lock,
                   exp_v.err, exp_v.rv, exp_v.rdata, exp_v.cu, exp_v.baud, exp_v.par, exp_v.lock);
        end
      end
    end
  end

  // One request, one cycle of valid, then the RESP cycle in which ack appears.
  task automatic req(input logic w, input logic [3:0] a, input logic [3:0] d);
    @(negedge clk);
    total++;
    if (bus.ack !== 1'b0) begin
      bad++;
      $display("FAIL idle_ack: got %b want 0 before addr=%0d", bus.ack, a);
    end
    bus.wr    = w;
    bus.addr  = a;
    bus.wdata = d;
    bus.valid = 1'b1;
    push_req(w, a, d);
    @(negedge clk);
    bus.valid = 1'b0;
  endtask

  task automatic check_drained(input string name);
    @(negedge clk);
    total++;
    if (sb.size() !== 0) begin
      bad++;
      $display("FAIL %s_drain: %0d responses never acked, want 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    bus.valid = 1'b0;
    bus.wr    = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    model_reset();
    @(negedge clk);
    total++;
    if ({bus.ack, bus.err, bus.rdata_valid, bus.rdata, cfg_update, baud, parity, locked}
        !== {1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 3'd1, 2'd0, 1'b0}) begin
      bad++;
      $display("FAIL reset_state: ack=%b err=%b rv=%b rdata=%h cu=%b baud=%0d par=%0d lock=%b, want 0 0 0 0 0 1 0 0",
               bus.ack, bus.err, bus.rdata_valid, bus.rdata, cfg_update, baud, parity, locked);
    end
    rst = 1'b0;
    req(1'b0, 4'd1, 4'h0);
    check_drained("reset");
  endtask

  task automatic test_write_read();
    req(1'b1, 4'd1, 4'h5);
    req(1'b0, 4'd1, 4'h0);
    req(1'b1, 4'd1, 4'h5);
    req(1'b1, 4'd1, 4'hF);
    req(1'b1, 4'd2, 4'h2);
    req(1'b0, 4'd2, 4'h0);
    check_drained("write_read");
  endtask

  task automatic test_range_scratch();
    req(1'b0, 4'd9, 4'h0);
    req(1'b1, 4'd9, 4'h3);
    req(1'b0, 4'd6, 4'h0);
    req(1'b0, 4'd15, 4'h0);
    req(1'b1, 4'd5, 4'hA);
    req(1'b0, 4'd5, 4'h0);
    req(1'b1, 4'd4, 4'h3);
    req(1'b0, 4'd4, 4'h0);
    check_drained("range_scratch");
  endtask

  task automatic test_back_to_back();
    logic [3:0] vals [6];
    int         acks_before;
    vals = '{4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7};
    acks_before = ack_seen;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if (bus.ack !== ((i % 2) == 1)) begin
        bad++;
        $display("FAIL b2b_ack_cycle%0d: got %b want %b", i, bus.ack, (i % 2) == 1);
      end
      bus.wr    = 1'b1;
      bus.addr  = 4'd1;
      bus.wdata = vals[i];
      bus.valid = 1'b1;
      if ((i % 2) == 0) push_req(1'b1, 4'd1, vals[i]);
    end
    @(negedge clk);
    bus.valid = 1'b0;
    check_drained("b2b");
    total++;
    if (ack_seen - acks_before !== 3) begin
      bad++;
      $display("FAIL b2b_ack_count: got %0d want 3", ack_seen - acks_before);
    end
  endtask

  task automatic test_restore();
    req(1'b1, 4'd1, 4'h6);
    req(1'b1, 4'd2, 4'h3);
    req(1'b1, 4'd4, 4'h9);
    req(1'b1, 4'd0, 4'h0);
    req(1'b1, 4'd0, 4'h1);
    req(1'b0, 4'd4, 4'h0);
    req(1'b1, 4'd0, 4'h1);
    check_drained("restore");
  endtask

  task automatic test_lock();
    req(1'b1, 4'd1, 4'h3);
    req(1'b1, 4'd3, 4'h1);
    req(1'b1, 4'd1, 4'h2);
    req(1'b1, 4'd0, 4'h1);
    req(1'b1, 4'd2, 4'h1);
    req(1'b0, 4'd0, 4'h0);
    req(1'b1, 4'd3, 4'h0);
    req(1'b0, 4'd1, 4'h0);
    req(1'b1, 4'd5, 4'hC);
    req(1'b0, 4'd3, 4'h0);
    check_drained("lock");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.wr    = 1'b0;
    bus.addr  = 4'd1;
    bus.valid = 1'b1;
    @(posedge clk);
    #2;
    rst       = 1'b1;
    bus.valid = 1'b0;
    #1;
    total++;
    if ({bus.ack, bus.rdata_valid, baud, parity, locked} !== {1'b0, 1'b0, 3'd1, 2'd0, 1'b0}) begin
      bad++;
      $display("FAIL mid_reset: ack=%b rv=%b baud=%0d par=%0d lock=%b, want 0 0 1 0 0",
               bus.ack, bus.rdata_valid, baud, parity, locked);
    end
    sb.delete();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (bus.ack !== 1'b0) begin
        bad++;
        $display("FAIL mid_reset_ack%0d: got %b want 0", i, bus.ack);
      end
    end
    req(1'b1, 4'd1, 4'h4);
    check_drained("reset_mid");
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench still running at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_write_read();
    test_range_scratch();
    test_back_to_back();
    test_restore();
    test_lock();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
